// File: rtl/sync_memory.sv
// sync_memory: single-port synchronous RAM that zero-fills itself after reset.
// Optional MEMORY_PARITY_EN adds a per-word even-parity bit with InjectError/ParityError.
module sync_memory #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  ReadWrite,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] DataIn,
`ifdef MEMORY_PARITY_EN
    input  logic                  InjectError,
    output logic                  ParityError,
`endif
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  Valid,
    output logic                  Ready
);
`ifdef MEMORY_PARITY_EN
    localparam int W = DATA_WIDTH + 1;
`else
    localparam int W = DATA_WIDTH;
`endif
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [W-1:0]          mem [DEPTH];
    logic [W-1:0]          word_in;
    logic [W-1:0]          word_rd;
    logic                  accept;
    logic                  wr;
    logic                  rd;
    logic                  clr;
    // Out-of-range addresses are rejected outright so they can never alias a real word.
    assign accept  = Enable && Ready && !Reset && ({1'b0, Address} < (ADDR_WIDTH+1)'(DEPTH));
    assign wr      = accept && !ReadWrite;
    assign rd      = accept && ReadWrite;
    assign clr     = (state == CLEAR) && !Reset;
    assign word_rd = mem[Address];
`ifdef MEMORY_PARITY_EN
    assign word_in = {^DataIn ^ InjectError, DataIn};
`else
    assign word_in = DataIn;
`endif
    always_ff @(posedge Clock) begin
        if (clr)
            mem[ptr] <= '0;
        else if (wr)
            mem[Address] <= word_in;
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= CLEAR;
            ptr     <= '0;
            Ready   <= 1'b0;
            Valid   <= 1'b0;
            DataOut <= '0;
`ifdef MEMORY_PARITY_EN
            ParityError <= 1'b0;
`endif
        end else begin
            Valid <= rd;
            if (rd) begin
                DataOut <= word_rd[DATA_WIDTH-1:0];
`ifdef MEMORY_PARITY_EN
                ParityError <= ^word_rd;
`endif
            end
            if (state == CLEAR) begin
                ptr <= ptr + 1'b1;
                if (ptr == ADDR_WIDTH'(DEPTH-1)) begin
                    state <= IDLE;
                    Ready <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sync_memory.sv
// tb_sync_memory: vector table plus hand sequences with a read scoreboard for sync_memory.
module tb_sync_memory;
    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Enable = 1'b0;
    logic       ReadWrite = 1'b0;
    logic [5:0] Address = '0;
    logic [3:0] DataIn = '0;
    logic [3:0] DataOut;
    logic       Valid;
    logic       Ready;
    logic       r2 = 1'b1;
    logic       e2 = 1'b0;
    logic       rw2 = 1'b0;
    logic [5:0] a2 = '0;
    logic [3:0] d2 = '0;
    logic [3:0] q2;
    logic       v2;
    logic       rdy2;
`ifdef MEMORY_PARITY_EN
    logic       InjectError = 1'b0;
    logic       ParityError;
    logic       inj2 = 1'b0;
    logic       pe2;
`endif
    int         checks = 0;
    int         errors = 0;
    logic [3:0] sb [$];

    typedef struct {
        logic       en;
        logic       rw;
        logic [5:0] a;
        logic [3:0] d;
        logic       ev;
        logic [3:0] ed;
    } vec_t;
    vec_t tv [24];

    always #5 Clock = ~Clock;

    sync_memory dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .ReadWrite(ReadWrite),
        .Address(Address), .DataIn(DataIn),
`ifdef MEMORY_PARITY_EN
        .InjectError(InjectError), .ParityError(ParityError),
`endif
        .DataOut(DataOut), .Valid(Valid), .Ready(Ready)
    );

    sync_memory #(.DEPTH(40)) dut40 (
        .Clock(Clock), .Reset(r2), .Enable(e2), .ReadWrite(rw2),
        .Address(a2), .DataIn(d2),
`ifdef MEMORY_PARITY_EN
        .InjectError(inj2), .ParityError(pe2),
`endif
        .DataOut(q2), .Valid(v2), .Ready(rdy2)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic step(input logic en, input logic rw, input logic [5:0] a, input logic [3:0] d,
                        input logic ev, input logic [3:0] ed, input string nm);
        logic [3:0] exp;
        Enable = en;
        ReadWrite = rw;
        Address = a;
        DataIn = d;
        if (ev) sb.push_back(ed);
        tick();
        Enable = 1'b0;
        check({nm, " valid"}, 32'(Valid), 32'(ev));
        if (ev) begin
            exp = sb.pop_front();
            if (Valid === 1'b1) check({nm, " data"}, 32'(DataOut), 32'(exp));
        end
    endtask

    task automatic clear_run(input bit gate, input string nm);
        int early = 0;
        int vcnt = 0;
        for (int i = 1; i <= 64; i++) begin
            if (gate) begin
                Enable = 1'b1;
                ReadWrite = i[0];
                Address = 6'd3;
                DataIn = 4'hF;
            end
            tick();
            if (i < 64 && Ready !== 1'b0) early++;
            if (Valid !== 1'b0) vcnt++;
        end
        Enable = 1'b0;
        check({nm, " ready early"}, 32'(early), 0);
        check({nm, " valid in clear"}, 32'(vcnt), 0);
        check({nm, " ready at 64"}, 32'(Ready), 1);
    endtask

    task automatic t2(input logic en, input logic rw, input logic [5:0] a, input logic [3:0] d);
        e2 = en;
        rw2 = rw;
        a2 = a;
        d2 = d;
        tick();
        e2 = 1'b0;
    endtask

    initial begin
        int early;
        int n;
        for (int i = 0; i < 10; i++) tv[i] = '{1'b1, 1'b0, 6'(i + 1), 4'(i + 1), 1'b0, 4'h0};
        for (int i = 0; i < 10; i++) tv[10 + i] = '{1'b1, 1'b1, 6'(i + 1), 4'h0, 1'b1, 4'(i + 1)};
        tv[20] = '{1'b1, 1'b0, 6'd20, 4'h9, 1'b0, 4'h0};
        tv[21] = '{1'b1, 1'b1, 6'd20, 4'h0, 1'b1, 4'h9};
        tv[22] = '{1'b0, 1'b1, 6'd20, 4'h0, 1'b0, 4'h0};
        tv[23] = '{1'b1, 1'b0, 6'd21, 4'hC, 1'b0, 4'h0};

        tick();
        tick();
        check("reset ready", 32'(Ready), 0);
        check("reset valid", 32'(Valid), 0);
        check("reset dataout", 32'(DataOut), 0);
        Reset = 1'b0;
        clear_run(1'b0, "first clear");

        foreach (tv[i]) step(tv[i].en, tv[i].rw, tv[i].a, tv[i].d, tv[i].ev, tv[i].ed, $sformatf("vec%0d", i));
        check("dataout hold", 32'(DataOut), 4'h9);

        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        early = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (Ready !== 1'b0) early++;
        end
        check("partial clear ready", 32'(early), 0);
        Reset = 1'b1;
        tick();
        check("mid-clear reset ready", 32'(Ready), 0);
        Reset = 1'b0;
        clear_run(1'b1, "restart clear");
        for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 6'(i), 4'h0, 1'b1, 4'h0, $sformatf("zero%0d", i));

        Reset = 1'b1;
        Enable = 1'b1;
        ReadWrite = 1'b1;
        Address = 6'd1;
        tick();
        check("idle reset valid", 32'(Valid), 0);
        check("idle reset dataout", 32'(DataOut), 0);
        Reset = 1'b0;
        Enable = 1'b0;
        clear_run(1'b0, "third clear");

`ifdef MEMORY_PARITY_EN
        InjectError = 1'b1;
        step(1'b1, 1'b0, 6'd7, 4'h5, 1'b0, 4'h0, "par wr7");
        InjectError = 1'b0;
        step(1'b1, 1'b1, 6'd7, 4'h0, 1'b1, 4'h5, "par rd7");
        check("parity err 7", 32'(ParityError), 1);
        step(1'b1, 1'b0, 6'd8, 4'h7, 1'b0, 4'h0, "par wr8");
        step(1'b1, 1'b1, 6'd8, 4'h0, 1'b1, 4'h7, "par rd8");
        check("parity err 8", 32'(ParityError), 0);
`endif

        r2 = 1'b0;
        n = 0;
        while (rdy2 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("d40 clear cycles", 32'(n), 40);
        t2(1'b1, 1'b0, 6'd39, 4'h7);
        t2(1'b1, 1'b0, 6'd45, 4'hF);
        t2(1'b1, 1'b1, 6'd39, 4'h0);
        check("d40 rd39 valid", 32'(v2), 1);
        check("d40 rd39 data", 32'(q2), 4'h7);
        t2(1'b1, 1'b1, 6'd45, 4'h0);
        check("d40 rd45 valid", 32'(v2), 0);
        check("d40 rd45 hold", 32'(q2), 4'h7);
        t2(1'b1, 1'b1, 6'd5, 4'h0);
        check("d40 rd5 data", 32'(q2), 4'h0);
        t2(1'b1, 1'b1, 6'd13, 4'h0);
        check("d40 rd13 valid", 32'(v2), 1);
        check("d40 rd13 data", 32'(q2), 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
